four_bit_serializer: RTL

Parallel-in, serial-out transmitter for the 4-bit register datapath: accepts a parallel word through a valid/ready handshake and shifts it out one bit at a time on a single-wire output with framing strobes. It sits downstream of the 4-bit holding register and drives the serial link that the matching deserializer samples. It is the reading/transmitting end of the parallel-load register path.

---
 rtl/four_bit_serializer_pkg.sv | 13 +
 rtl/four_bit_serializer_bit_period_counter.sv | 18 +
 rtl/four_bit_serializer.sv | 102 ++++++++++
 3 files changed

// File: rtl/four_bit_serializer_pkg.sv
// four_bit_serializer_pkg: shared state encoding, parity helper and default geometry.
package four_bit_serializer_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_BIT_CYCLES = 1;
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_e;
  function automatic logic even_parity(input logic [63:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/four_bit_serializer_bit_period_counter.sv
// bit_period_counter: counts BIT_CYCLES clocks per serial bit and ticks on the last one.
module bit_period_counter #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(BIT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == CW'(BIT_CYCLES - 1);
  always_comb cnt_d = (clr || tick) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/four_bit_serializer.sv
// four_bit_serializer: valid/ready parallel-in, framed serial-out transmitter.
// Define PARITY_EN to append an even-parity bit after the data bits.
module four_bit_serializer
  import four_bit_serializer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic sout_q, sout_d, valid_q, valid_d, first_q, first_d, done_q, done_d;
  logic take, tick, last_bit, head;
`ifdef PARITY_EN
  logic par_q, par_d;
`endif
  assign in_ready   = state_q == IDLE && !rst;
  assign busy       = state_q == SHIFT || state_q == PARITY;
  assign take       = in_valid && in_ready;
  assign last_bit   = bit_q == BW'(WIDTH - 1);
  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_first = first_q;
  assign done       = done_q;
  bit_period_counter #(.BIT_CYCLES(BIT_CYCLES)) u_period (
    .clk (clk),
    .rst (rst),
    .clr (take),
    .en  (busy),
    .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    if (take) begin
      state_d = SHIFT;
      sr_d    = d;
      bit_d   = '0;
    end else if (state_q == SHIFT && tick) begin
      sr_d  = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
      bit_d = last_bit ? '0 : bit_q + BW'(1);
`ifdef PARITY_EN
      if (last_bit) state_d = PARITY;
`else
      if (last_bit) state_d = IDLE;
`endif
    end
`ifdef PARITY_EN
    else if (state_q == PARITY && tick) state_d = IDLE;
`endif
  end
  // Registered outputs are decoded from next state so the first bit appears right after capture.
  always_comb begin
    head    = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
    valid_d = state_d != IDLE;
    first_d = state_d == SHIFT && bit_d == '0;
    done_d  = state_q != IDLE && state_d == IDLE;
`ifdef PARITY_EN
    par_d   = take ? even_parity(64'(d)) : par_q;
    sout_d  = state_d == SHIFT ? head : state_d == PARITY ? par_d : 1'b0;
`else
    sout_d  = state_d == SHIFT ? head : 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      first_q <= first_d;
      done_q  <= done_d;
    end
`ifdef PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
`endif
endmodule
